// File: rtl/shift_exec_stage.sv
// Shift execution stage: SLL/SRL/SRA/ROL computed by two barrel shifters,
// results queued with their tags in a small FIFO for the writeback side.
`timescale 1ns/1ps

module shift32 #(
    parameter bit LEFT = 1'b0
) (
    input  logic [31:0] d,
    input  logic [4:0]  s,
    input  logic        fill,
    output logic [31:0] y
);
    logic [31:0] stg [6];

    assign stg[0] = d;

    // Log barrel: stage gi shifts by 2^gi, injecting the fill bit.
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        if (LEFT) begin : g_left
            assign stg[gi+1] = s[gi] ? {stg[gi][31-SH:0], {SH{fill}}} : stg[gi];
        end else begin : g_right
            assign stg[gi+1] = s[gi] ? {{SH{fill}}, stg[gi][31:SH]} : stg[gi];
        end
    end

    assign y = stg[5];
endmodule

module shift_exec_stage #(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [31:0]          IN_D,
    input  logic [31:0]          IN_S,
    input  logic [1:0]           IN_OP,
    input  logic [3:0]           IN_TAG,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [31:0]          OUT_Y,
    output logic [3:0]           OUT_TAG,
    output logic                 OUT_ZERO,
    output logic [CNT_WIDTH-1:0] OP_CNT
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 37;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [4:0]  amt;
    logic [4:0]  r_amt;
    logic        oob;
    logic        r_fill;
    logic [31:0] shl_y;
    logic [31:0] shr_y;
    logic [31:0] result;

    assign amt    = IN_S[4:0];
    assign oob    = |IN_S[31:5];
    // Rotate reuses the right shifter for the wrapped-around bits; s=0 yields d|d.
    assign r_amt  = (IN_OP == 2'b11) ? (5'd0 - amt) : amt;
    assign r_fill = (IN_OP == OP_SRA) & IN_D[31];

    shift32 #(.LEFT(1'b1)) u_shl (.d(IN_D), .s(amt),   .fill(1'b0),   .y(shl_y));
    shift32 #(.LEFT(1'b0)) u_shr (.d(IN_D), .s(r_amt), .fill(r_fill), .y(shr_y));

    always_comb begin
        result = shl_y | shr_y;
        case (IN_OP)
            OP_SLL:  result = oob ? 32'd0 : shl_y;
            OP_SRL:  result = oob ? 32'd0 : shr_y;
            OP_SRA:  result = oob ? {32{IN_D[31]}} : shr_y;
            default: result = shl_y | shr_y;
        endcase
    end

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;
    logic [EW-1:0]        mem_q [BUF_DEPTH];
    logic [EW-1:0]        entry_d;
    logic [EW-1:0]        head;
    logic                 push;
    logic                 pop;

    assign IN_READY  = (count_q < CW'(BUF_DEPTH));
    assign OUT_VALID = (count_q != '0);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign entry_d   = {(result == 32'd0), IN_TAG, result};

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        op_cnt_d = push ? op_cnt_q + CNT_WIDTH'(1) : op_cnt_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            op_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign OUT_Y    = OUT_VALID ? head[31:0]  : 32'd0;
    assign OUT_TAG  = OUT_VALID ? head[35:32] : 4'd0;
    assign OUT_ZERO = OUT_VALID ? head[36]    : 1'b0;
    assign OP_CNT   = op_cnt_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// Randomised bench for shift_exec_stage: a reference model fills a scoreboard
// queue at issue time and an independent monitor checks every popped result.
`timescale 1ns/1ps

module tb_shift_exec_stage;
    localparam int CW = 8;
    localparam int DEPTH = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [31:0]   IN_D = '0;
    logic [31:0]   IN_S = '0;
    logic [1:0]    IN_OP = '0;
    logic [3:0]    IN_TAG = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [31:0]   OUT_Y;
    logic [3:0]    OUT_TAG;
    logic          OUT_ZERO;
    logic [CW-1:0] OP_CNT;

    shift_exec_stage #(.BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_D(IN_D), .IN_S(IN_S), .IN_OP(IN_OP), .IN_TAG(IN_TAG),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_Y(OUT_Y), .OUT_TAG(OUT_TAG), .OUT_ZERO(OUT_ZERO),
        .OP_CNT(OP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   pops = 0;
    bit   mon_en = 1'b0;

    // Reference: plain arithmetic on the operation definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s,
                                              input logic [1:0] op);
        logic signed [31:0] sd;
        logic [63:0]        wide;
        int                 r;
        sd   = d;
        r    = int'(s % 32);
        wide = {d, d} << r;
        case (op)
            2'd0:    return (s >= 32) ? 32'd0 : d << s;
            2'd1:    return (s >= 32) ? 32'd0 : d >> s;
            2'd2:    return (s >= 32) ? {32{d[31]}} : 32'(sd >>> s);
            default: return wide[63:32];
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge that
    // follows the accepting rising edge.
    task automatic issue(input logic [31:0] d, input logic [31:0] s, input logic [1:0] op,
                         input logic [3:0] tag, output int stalls);
        exp_t e;
        bit   timed_out;
        stalls    = 0;
        timed_out = 1'b0;
        IN_D      = d;
        IN_S      = s;
        IN_OP     = op;
        IN_TAG    = tag;
        IN_VALID  = 1'b1;
        while (!IN_READY && !timed_out) begin
            @(negedge CLK);
            stalls++;
            if (stalls > 200) timed_out = 1'b1;
        end
        if (timed_out) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=stalled required=accepted tag=%0d", tag);
            IN_VALID = 1'b0;
        end else begin
            e.y    = ref_shift(d, s, op);
            e.tag  = tag;
            e.zero = (e.y == 32'd0);
            exp_q.push_back(e);
            model_cnt++;
            @(negedge CLK);
            IN_VALID = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor samples 1ns before each rising edge, when every input is settled.
    always @(negedge CLK) begin
        #4;
        if (mon_en && RST && OUT_VALID && OUT_READY) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected actual tag=%0d y=%h required=no output", OUT_TAG, OUT_Y);
            end else begin
                mon_e = exp_q.pop_front();
                if (OUT_Y !== mon_e.y || OUT_TAG !== mon_e.tag || OUT_ZERO !== mon_e.zero) begin
                    errors++;
                    $display("FAIL out_entry actual y=%h tag=%0d zero=%0d required y=%h tag=%0d zero=%0d",
                             OUT_Y, OUT_TAG, OUT_ZERO, mon_e.y, mon_e.tag, mon_e.zero);
                end else begin
                    $display("pop tag=%0d y=%h zero=%0d", OUT_TAG, OUT_Y, OUT_ZERO);
                end
            end
        end
    end

    task automatic directed(input logic [31:0] d, input logic [31:0] s, input logic [1:0] op,
                            input logic [3:0] tag, input logic [31:0] req_y, input string name);
        int st;
        issue(d, s, op, tag, st);
        check(name, 64'(OUT_Y), 64'(req_y));
    endtask

    initial begin
        int  st;
        int  total;
        int  pops0;
        bit  done;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        check("rst_in_ready",  64'(IN_READY),  64'd1);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_out_y",     64'(OUT_Y),     64'd0);
        check("rst_out_tag",   64'(OUT_TAG),   64'd0);
        check("rst_out_zero",  64'(OUT_ZERO),  64'd0);
        check("rst_op_cnt",    64'(OP_CNT),    64'd0);

        mon_en    = 1'b1;
        OUT_READY = 1'b1;

        // Directed amount, sign and rotate cases; each result is the head right after acceptance.
        directed(32'h0000_0001, 32'd4,         2'd0, 4'd3, 32'h0000_0010, "sll_basic");
        check("first_out_valid", 64'(OUT_VALID), 64'd1);
        check("first_out_tag",   64'(OUT_TAG),   64'd3);
        check("first_op_cnt",    64'(OP_CNT),    64'd1);
        directed(32'h8000_0000, 32'd4,         2'd2, 4'd1, 32'hF800_0000, "sra_s4");
        directed(32'h8000_0000, 32'd40,        2'd2, 4'd2, 32'hFFFF_FFFF, "sra_s40");
        directed(32'h1234_5678, 32'd40,        2'd1, 4'd4, 32'h0000_0000, "srl_s40");
        check("srl_s40_zero", 64'(OUT_ZERO), 64'd1);
        directed(32'hFFFF_FFFF, 32'd32,        2'd0, 4'd5, 32'h0000_0000, "sll_s32");
        directed(32'h8000_0001, 32'd1,         2'd3, 4'd6, 32'h0000_0003, "rol_s1");
        directed(32'h8000_0001, 32'h0000_0021, 2'd3, 4'd7, 32'h0000_0003, "rol_s33");
        directed(32'hDEAD_BEEF, 32'd0,         2'd3, 4'd8, 32'hDEAD_BEEF, "rol_s0");
        directed(32'hDEAD_BEEF, 32'h0000_0040, 2'd3, 4'd9, 32'hDEAD_BEEF, "rol_s64");
        directed(32'h7000_0000, 32'd31,        2'd2, 4'd10, 32'h0000_0000, "sra_pos_s31");
        drain("drain_directed");

        // Backpressure: two pushes fill the FIFO, the third waits for a pop.
        OUT_READY = 1'b0;
        issue(32'h0000_00F0, 32'd4, 2'd1, 4'd0, st);
        issue(32'h0000_00F0, 32'd8, 2'd0, 4'd1, st);
        fork
            begin
                issue(32'hF000_000F, 32'd4, 2'd3, 4'd2, st);
            end
            begin
                check("full_in_ready",   64'(IN_READY),  64'd0);
                check("full_out_valid",  64'(OUT_VALID), 64'd1);
                @(negedge CLK);
                check("full_held",       64'(IN_READY),  64'd0);
                OUT_READY = 1'b1;
                @(negedge CLK);
                check("ready_after_pop", 64'(IN_READY),  64'd1);
            end
        join
        check("third_was_held", 64'(st >= 2), 64'd1);
        drain("drain_backpressure");

        // Streaming: with OUT_READY high every request is accepted without stalling.
        pops0 = pops;
        total = 0;
        for (int i = 0; i < 20; i++) begin
            issue($urandom, $urandom_range(0, 40), 2'($urandom_range(0, 3)), 4'(i), st);
            total += st;
        end
        @(negedge CLK);
        check("stream_stalls",  64'(total),        64'd0);
        check("stream_pops",    64'(pops - pops0), 64'd20);
        check("stream_op_cnt",  64'(OP_CNT),       64'(model_cnt % (1 << CW)));
        drain("drain_stream");

        // Random traffic with random downstream backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge CLK);
                    issue($urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                          2'($urandom_range(0, 3)), 4'($urandom), st);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge CLK);
                    OUT_READY = ($urandom_range(0, 2) != 0);
                end
            end
        join
        OUT_READY = 1'b1;
        drain("drain_random");
        check("random_op_cnt", 64'(OP_CNT), 64'(model_cnt % (1 << CW)));

        // Asynchronous reset in the middle of a cycle with two entries queued.
        OUT_READY = 1'b0;
        issue(32'h0000_0011, 32'd1, 2'd0, 4'd12, st);
        issue(32'h0000_0022, 32'd1, 2'd0, 4'd13, st);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("arst_out_valid", 64'(OUT_VALID), 64'd0);
        check("arst_op_cnt",    64'(OP_CNT),    64'd0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b1;
        issue(32'h0000_0003, 32'd2, 2'd0, 4'd14, st);
        check("post_rst_tag", 64'(OUT_TAG), 64'd14);
        drain("drain_post_reset");

        // Counter wrap at 2^CW.
        while (model_cnt < (1 << CW) - 1) begin
            issue($urandom, $urandom_range(0, 40), 2'($urandom_range(0, 3)), 4'(model_cnt), st);
        end
        check("cnt_max", 64'(OP_CNT), 64'((1 << CW) - 1));
        issue(32'h0000_0001, 32'd0, 2'd0, 4'd15, st);
        check("cnt_wrap", 64'(OP_CNT), 64'd0);
        drain("drain_final");
        check("final_out_valid", 64'(OUT_VALID), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
